// File: rtl/ikaopll_bus_writer_pkg.sv
// Shared types and default bus timing for the OPLL host write sequencer.
package ikaopll_bus_writer_pkg;

  localparam int unsigned DEF_WR_PULSE  = 2;
  localparam int unsigned DEF_ADDR_WAIT = 12;
  localparam int unsigned DEF_DATA_WAIT = 84;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_A_SETUP,
    ST_A_STROBE,
    ST_A_WAIT,
    ST_D_SETUP,
    ST_D_STROBE,
    ST_D_WAIT
  } wr_state_t;

  typedef struct packed {
    logic [7:0] addr;
    logic [7:0] data;
  } wr_req_t;

  // Timer must hold the largest reload value; never narrower than 7 bits.
  function automatic int unsigned timer_width(input int unsigned a, input int unsigned b,
                                              input int unsigned c);
    int unsigned m;
    int unsigned w;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    w = $clog2(m + 1);
    return (w < 7) ? 7 : w;
  endfunction

endpackage

// File: rtl/ikaopll_bus_writer_if.sv
// Host request handshake plus YM2413 CPU-bus pins of the write sequencer.
interface ikaopll_bus_writer_if;

  logic       i_REQ_VALID;
  logic       o_REQ_READY;
  logic [7:0] i_REQ_ADDR;
  logic [7:0] i_REQ_DATA;
  logic       o_CS_n;
  logic       o_WR_n;
  logic       o_A0;
  logic [7:0] o_D;

  modport slave (
    input  i_REQ_VALID, i_REQ_ADDR, i_REQ_DATA,
    output o_REQ_READY, o_CS_n, o_WR_n, o_A0, o_D
  );

  modport master (
    output i_REQ_VALID, i_REQ_ADDR, i_REQ_DATA,
    input  o_REQ_READY, o_CS_n, o_WR_n, o_A0, o_D
  );

endinterface

// File: rtl/ikaopll_wrfifo.sv
// Synchronous request FIFO; pushes beyond full and pops beyond empty are ignored.
module ikaopll_wrfifo
  import ikaopll_bus_writer_pkg::*;
#(
  parameter int unsigned DEPTH = 16
) (
  input  logic                     i_CLK,
  input  logic                     i_RST,
  input  logic                     i_PUSH,
  input  logic                     i_POP,
  input  wr_req_t                  i_WDATA,
  output wr_req_t                  o_RDATA,
  output logic                     o_FULL,
  output logic                     o_EMPTY,
  output logic [$clog2(DEPTH):0]   o_LEVEL
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;

  wr_req_t          r_mem [DEPTH];
  logic [AW-1:0]    r_wptr;
  logic [AW-1:0]    r_rptr;
  logic [LW-1:0]    r_level;
  logic             w_push;
  logic             w_pop;

  assign o_FULL  = (r_level == LW'(DEPTH));
  assign o_EMPTY = (r_level == '0);
  assign o_LEVEL = r_level;
  assign o_RDATA = r_mem[r_rptr];
  assign w_push  = i_PUSH && !o_FULL;
  assign w_pop   = i_POP && !o_EMPTY;

  always_ff @(posedge i_CLK) begin
    if (w_push) r_mem[r_wptr] <= i_WDATA;
  end

  always_ff @(posedge i_CLK) begin
    if (i_RST) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_level <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + 1'b1;
        2'b01:   r_level <= r_level - 1'b1;
        default: r_level <= r_level;
      endcase
    end
  end

endmodule

// File: rtl/ikaopll_bus_writer.sv
// Replays buffered (addr, data) requests as two-phase YM2413 bus writes,
// with all strobe and recovery timing counted in phiM ticks.
module ikaopll_bus_writer
  import ikaopll_bus_writer_pkg::*;
#(
  parameter int unsigned DEPTH               = 16,
  parameter int unsigned WR_PULSE            = DEF_WR_PULSE,
  parameter int unsigned ADDR_WAIT           = DEF_ADDR_WAIT,
  parameter int unsigned DATA_WAIT           = DEF_DATA_WAIT,
  parameter bit          SKIP_REDUNDANT_ADDR = 1'b0
) (
  input  logic                     i_EMUCLK,
  input  logic                     i_RST,
  input  logic                     i_phiM_PCEN_n,
  ikaopll_bus_writer_if.slave      bus,
  output logic                     o_BUSY,
  output logic [$clog2(DEPTH):0]   o_LEVEL
);

  localparam int unsigned TW = timer_width(WR_PULSE, ADDR_WAIT, DATA_WAIT);

  wr_state_t   r_state, w_state_nx;
  logic [TW-1:0] r_timer, w_timer_nx;
  wr_req_t     r_work, w_work_nx;
  logic [7:0]  r_last_addr, w_last_addr_nx;
  logic        r_last_vld, w_last_vld_nx;
  logic        r_cs_n, w_cs_n_nx;
  logic        r_wr_n, w_wr_n_nx;
  logic        r_a0, w_a0_nx;
  logic [7:0]  r_d, w_d_nx;

  logic        w_tick;
  logic        w_pop;
  logic        w_fetch;
  logic        w_full;
  logic        w_empty;
  wr_req_t     w_head;
  wr_req_t     w_req;

  assign w_tick      = !i_phiM_PCEN_n;
  assign w_req.addr  = bus.i_REQ_ADDR;
  assign w_req.data  = bus.i_REQ_DATA;

  ikaopll_wrfifo #(.DEPTH(DEPTH)) u_fifo (
    .i_CLK   (i_EMUCLK),
    .i_RST   (i_RST),
    .i_PUSH  (bus.i_REQ_VALID),
    .i_POP   (w_pop),
    .i_WDATA (w_req),
    .o_RDATA (w_head),
    .o_FULL  (w_full),
    .o_EMPTY (w_empty),
    .o_LEVEL (o_LEVEL)
  );

  always_comb begin
    w_state_nx     = r_state;
    w_timer_nx     = r_timer;
    w_work_nx      = r_work;
    w_last_addr_nx = r_last_addr;
    w_last_vld_nx  = r_last_vld;
    w_pop          = 1'b0;
    w_fetch        = 1'b0;
    w_cs_n_nx      = r_cs_n;
    w_wr_n_nx      = r_wr_n;
    w_a0_nx        = r_a0;
    w_d_nx         = r_d;

    if (w_tick) begin
      case (r_state)
        ST_IDLE: w_fetch = 1'b1;
        ST_A_SETUP: begin
          w_state_nx = ST_A_STROBE;
          w_timer_nx = TW'(WR_PULSE - 1);
        end
        ST_A_STROBE: begin
          if (r_timer == '0) begin
            w_last_addr_nx = r_work.addr;
            w_last_vld_nx  = 1'b1;
            w_timer_nx     = TW'(ADDR_WAIT - 1);
            w_state_nx     = ST_A_WAIT;
          end else begin
            w_timer_nx = r_timer - 1'b1;
          end
        end
        ST_A_WAIT: begin
          if (r_timer == '0) w_state_nx = ST_D_SETUP;
          else               w_timer_nx = r_timer - 1'b1;
        end
        ST_D_SETUP: begin
          w_state_nx = ST_D_STROBE;
          w_timer_nx = TW'(WR_PULSE - 1);
        end
        ST_D_STROBE: begin
          if (r_timer == '0) begin
            w_timer_nx = TW'(DATA_WAIT - 1);
            w_state_nx = ST_D_WAIT;
          end else begin
            w_timer_nx = r_timer - 1'b1;
          end
        end
        ST_D_WAIT: begin
          if (r_timer == '0) begin
            w_state_nx = ST_IDLE;
            w_fetch    = 1'b1;
          end else begin
            w_timer_nx = r_timer - 1'b1;
          end
        end
        default: w_state_nx = ST_IDLE;
      endcase

      // The final D_WAIT tick doubles as the IDLE fetch so bursts run back-to-back.
      if (w_fetch && !w_empty) begin
        w_pop     = 1'b1;
        w_work_nx = w_head;
        if (SKIP_REDUNDANT_ADDR && r_last_vld && (w_head.addr == r_last_addr))
          w_state_nx = ST_D_SETUP;
        else
          w_state_nx = ST_A_SETUP;
      end
    end

    // Bus pins are registered from the state being entered, so they change on the tick edge.
    case (w_state_nx)
      ST_A_SETUP: begin
        w_cs_n_nx = 1'b0;
        w_wr_n_nx = 1'b1;
        w_a0_nx   = 1'b0;
        w_d_nx    = w_work_nx.addr;
      end
      ST_A_STROBE, ST_D_STROBE: begin
        w_cs_n_nx = 1'b0;
        w_wr_n_nx = 1'b0;
      end
      ST_D_SETUP: begin
        w_cs_n_nx = 1'b0;
        w_wr_n_nx = 1'b1;
        w_a0_nx   = 1'b1;
        w_d_nx    = w_work_nx.data;
      end
      default: begin
        w_cs_n_nx = 1'b1;
        w_wr_n_nx = 1'b1;
      end
    endcase
  end

  always_ff @(posedge i_EMUCLK) begin
    if (i_RST) begin
      r_state     <= ST_IDLE;
      r_timer     <= '0;
      r_work      <= '0;
      r_last_addr <= '0;
      r_last_vld  <= 1'b0;
      r_cs_n      <= 1'b1;
      r_wr_n      <= 1'b1;
      r_a0        <= 1'b0;
      r_d         <= '0;
    end else begin
      r_state     <= w_state_nx;
      r_timer     <= w_timer_nx;
      r_work      <= w_work_nx;
      r_last_addr <= w_last_addr_nx;
      r_last_vld  <= w_last_vld_nx;
      r_cs_n      <= w_cs_n_nx;
      r_wr_n      <= w_wr_n_nx;
      r_a0        <= w_a0_nx;
      r_d         <= w_d_nx;
    end
  end

  assign bus.o_REQ_READY = !w_full;
  assign bus.o_CS_n      = r_cs_n;
  assign bus.o_WR_n      = r_wr_n;
  assign bus.o_A0        = r_a0;
  assign bus.o_D         = r_d;
  assign o_BUSY          = (r_state != ST_IDLE) || (o_LEVEL != '0);

endmodule
